// File: rtl/fcore_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fcore_dma_pkg
//  Description : Shared definitions for the fCore DMA read path: the read
//                initiator state encoding, the reserved register address
//                and the default datapath/address widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package fcore_dma_pkg;

    localparam int unsigned c_DEFAULT_DATAPATH_WIDTH = 32;
    localparam int unsigned c_DEFAULT_ADDR_WIDTH     = 8;
    localparam int unsigned c_DEFAULT_MAX_CHANNELS   = 16;
    localparam int unsigned c_DEFAULT_TIMEOUT_CYCLES = 64;

    // The fCore endpoint never answers a read of this address.
    localparam int unsigned c_RESERVED_ADDR = 0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQUEST   = 3'd1,
        WAIT_RESP = 3'd2,
        OUTPUT    = 3'd3,
        DONE      = 3'd4
    } fcore_dma_read_state_t;

endpackage : fcore_dma_pkg
`default_nettype wire

// File: rtl/fcore_dma_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : fcore_dma_timeout_counter
//  Description : Response watchdog. Cleared by load, counts while enable is
//                high, and flags expired during the TIMEOUT_CYCLES-th enabled
//                cycle. Only instantiated when FCORE_DMA_READ_TIMEOUT_EN is
//                defined.
//  Ports       : clock, reset  - clock and synchronous active-high reset
//                load          - clear the count
//                enable        - advance the count
//                expired       - high on the final enabled cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module fcore_dma_timeout_counter
    import fcore_dma_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int unsigned c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || load) begin
            r_count <= '0;
        end else if (enable && (r_count != c_LAST)) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign expired = enable && (r_count == c_LAST);

endmodule : fcore_dma_timeout_counter
`default_nettype wire

// File: rtl/fcore_dma_read_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : fcore_dma_read_initiator
//  Description : Initiator side of the fCore DMA read protocol. A start pulse
//                sweeps base_address .. base_address+count-1 (mod 2^ADDR_WIDTH),
//                one outstanding read at a time, and forwards each response
//                as a tagged beat (dest = address, tlast on the final one).
//                Address 0 is never requested; it yields data 0.
//  Options     : FCORE_DMA_READ_TIMEOUT_EN - enables the response watchdog;
//                a silent endpoint then yields data 0 and a sticky
//                timeout_error instead of stalling the sweep forever.
//  Ports       : clock, reset                 - clock, sync active-high reset
//                start, n_channels, base_address - sweep command
//                axis_dma_read_request_*      - address stream to endpoint
//                axis_dma_read_response_*     - data from endpoint (ready=1)
//                data_out_*                   - tagged output stream
//                busy, done, timeout_error    - status
//  Revision    : 1.0 - initial release
// ============================================================================
module fcore_dma_read_initiator
    import fcore_dma_pkg::*;
#(
    parameter int unsigned DATAPATH_WIDTH = c_DEFAULT_DATAPATH_WIDTH,
    parameter int unsigned ADDR_WIDTH     = c_DEFAULT_ADDR_WIDTH,
    parameter int unsigned MAX_CHANNELS   = c_DEFAULT_MAX_CHANNELS,
    parameter int unsigned TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [$clog2(MAX_CHANNELS):0] n_channels,
    input  logic [ADDR_WIDTH-1:0]         base_address,
    output logic                          axis_dma_read_request_valid,
    input  logic                          axis_dma_read_request_ready,
    output logic [DATAPATH_WIDTH-1:0]     axis_dma_read_request_data,
    input  logic                          axis_dma_read_response_valid,
    output logic                          axis_dma_read_response_ready,
    input  logic [DATAPATH_WIDTH-1:0]     axis_dma_read_response_data,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic [DATAPATH_WIDTH-1:0]     data_out_data,
    output logic [ADDR_WIDTH-1:0]         data_out_dest,
    output logic                          data_out_tlast,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout_error
);

    localparam int unsigned c_CW = $clog2(MAX_CHANNELS) + 1;
    localparam logic [c_CW-1:0]       c_MAX_COUNT = c_CW'(MAX_CHANNELS);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ZERO = ADDR_WIDTH'(c_RESERVED_ADDR);

    if ((MAX_CHANNELS < 1) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("fcore_dma_read_initiator: MAX_CHANNELS and TIMEOUT_CYCLES must be >= 1");
    end

    fcore_dma_read_state_t r_state, w_state_next;

    logic [ADDR_WIDTH-1:0]     r_base, w_base_next;
    logic [c_CW-1:0]           r_count, w_count_next;
    logic [c_CW-1:0]           r_index, w_index_next;
    logic [c_CW-1:0]           w_start_count;
    logic [ADDR_WIDTH-1:0]     w_addr_cur, w_addr_next;
    logic                      w_last_cur, w_last_next;
    logic                      w_out_load;
    logic [DATAPATH_WIDTH-1:0] w_out_load_data;

    logic                      r_req_valid;
    logic [DATAPATH_WIDTH-1:0] r_req_data;
    logic                      r_out_valid;
    logic [DATAPATH_WIDTH-1:0] r_out_data;
    logic [ADDR_WIDTH-1:0]     r_out_dest;
    logic                      r_out_tlast;
    logic                      r_busy;
    logic                      r_done;

`ifdef FCORE_DMA_READ_TIMEOUT_EN
    logic w_timeout_expired;
    logic w_set_error;
    logic w_clear_error;
    logic r_timeout_error;
`endif

    assign w_start_count = (n_channels > c_MAX_COUNT) ? c_MAX_COUNT : n_channels;

    // Address wraps naturally in ADDR_WIDTH bits.
    assign w_addr_cur  = r_base + ADDR_WIDTH'(r_index);
    assign w_addr_next = w_base_next + ADDR_WIDTH'(w_index_next);
    assign w_last_cur  = (r_index == (r_count - c_CW'(1)));
    assign w_last_next = (w_index_next == (w_count_next - c_CW'(1)));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_count <= '0;
            r_index <= '0;
        end else begin
            r_state <= w_state_next;
            r_base  <= w_base_next;
            r_count <= w_count_next;
            r_index <= w_index_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_base_next     = r_base;
        w_count_next    = r_count;
        w_index_next    = r_index;
        w_out_load      = 1'b0;
        w_out_load_data = '0;
`ifdef FCORE_DMA_READ_TIMEOUT_EN
        w_set_error     = 1'b0;
        w_clear_error   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_base_next  = base_address;
                    w_count_next = w_start_count;
                    w_index_next = '0;
`ifdef FCORE_DMA_READ_TIMEOUT_EN
                    w_clear_error = 1'b1;
`endif
                    w_state_next = (w_start_count == '0) ? DONE : REQUEST;
                end
            end
            REQUEST: begin
                if (w_addr_cur == c_ADDR_ZERO) begin
                    // Reserved address: skip the endpoint, emit zero.
                    w_out_load   = 1'b1;
                    w_state_next = OUTPUT;
                end else if (r_req_valid && axis_dma_read_request_ready) begin
                    w_state_next = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (axis_dma_read_response_valid) begin
                    w_out_load      = 1'b1;
                    w_out_load_data = axis_dma_read_response_data;
                    w_state_next    = OUTPUT;
                end
`ifdef FCORE_DMA_READ_TIMEOUT_EN
                else if (w_timeout_expired) begin
                    w_out_load   = 1'b1;
                    w_set_error  = 1'b1;
                    w_state_next = OUTPUT;
                end
`endif
            end
            OUTPUT: begin
                if (data_out_ready) begin
                    if (w_last_cur) begin
                        w_state_next = DONE;
                    end else begin
                        w_index_next = r_index + c_CW'(1);
                        w_state_next = REQUEST;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Every output is registered from the next state so no ready input has a
    // combinational path to a valid output.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_req_valid <= 1'b0;
            r_req_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_dest  <= '0;
            r_out_tlast <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_req_valid <= (w_state_next == REQUEST) && (w_addr_next != c_ADDR_ZERO);
            r_req_data  <= ((w_state_next == REQUEST) && (w_addr_next != c_ADDR_ZERO))
                           ? DATAPATH_WIDTH'(w_addr_next) : '0;
            // r_out_data doubles as the response holding register.
            if (w_out_load) begin
                r_out_data <= w_out_load_data;
            end else if (w_state_next != OUTPUT) begin
                r_out_data <= '0;
            end
            r_out_valid <= (w_state_next == OUTPUT);
            r_out_dest  <= (w_state_next == OUTPUT) ? w_addr_next : '0;
            r_out_tlast <= (w_state_next == OUTPUT) && w_last_next;
            r_busy      <= (w_state_next == REQUEST) || (w_state_next == WAIT_RESP) ||
                           (w_state_next == OUTPUT);
            r_done      <= (w_state_next == DONE);
        end
    end

`ifdef FCORE_DMA_READ_TIMEOUT_EN
    fcore_dma_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .clock   (clock),
        .reset   (reset),
        .load    (r_state != WAIT_RESP),
        .enable  (r_state == WAIT_RESP),
        .expired (w_timeout_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_timeout_error <= 1'b0;
        end else if (w_clear_error) begin
            r_timeout_error <= 1'b0;
        end else if (w_set_error) begin
            r_timeout_error <= 1'b1;
        end
    end

    assign timeout_error = r_timeout_error;
`else
    assign timeout_error = 1'b0;
`endif

    assign axis_dma_read_request_valid  = r_req_valid;
    assign axis_dma_read_request_data   = r_req_data;
    assign axis_dma_read_response_ready = 1'b1;
    assign data_out_valid               = r_out_valid;
    assign data_out_data                = r_out_data;
    assign data_out_dest                = r_out_dest;
    assign data_out_tlast               = r_out_tlast;
    assign busy                         = r_busy;
    assign done                         = r_done;

endmodule : fcore_dma_read_initiator
`default_nettype wire

// File: tb/tb_fcore_dma_read_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fcore_dma_read_initiator
//  Description : Self-checking bench for fcore_dma_read_initiator. A
//                behavioural endpoint answers each request two cycles after
//                the handshake with 0x100 + address; a table of sweeps is
//                applied, followed by hand-written reset, ignored-start and
//                (with FCORE_DMA_READ_TIMEOUT_EN) timeout sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fcore_dma_read_initiator;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int CW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] n_channels = '0;
    logic [AW-1:0] base_address = '0;
    logic          req_valid;
    logic          req_ready = 1'b1;
    logic [DW-1:0] req_data;
    logic          resp_valid = 1'b0;
    logic          resp_ready;
    logic [DW-1:0] resp_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_dest;
    logic          out_tlast;
    logic          busy;
    logic          done;
    logic          timeout_error;

    fcore_dma_read_initiator #(
        .DATAPATH_WIDTH (DW),
        .ADDR_WIDTH     (AW),
        .MAX_CHANNELS   (16),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clock                        (clock),
        .reset                        (reset),
        .start                        (start),
        .n_channels                   (n_channels),
        .base_address                 (base_address),
        .axis_dma_read_request_valid  (req_valid),
        .axis_dma_read_request_ready  (req_ready),
        .axis_dma_read_request_data   (req_data),
        .axis_dma_read_response_valid (resp_valid),
        .axis_dma_read_response_ready (resp_ready),
        .axis_dma_read_response_data  (resp_data),
        .data_out_valid               (out_valid),
        .data_out_ready               (out_ready),
        .data_out_data                (out_data),
        .data_out_dest                (out_dest),
        .data_out_tlast               (out_tlast),
        .busy                         (busy),
        .done                         (done),
        .timeout_error                (timeout_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] dest;
        logic          last;
        int            c;
    } beat_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [CW-1:0] n;
        int            ready_mode;
        int            exp_beats;
        int            exp_reqs;
        logic [AW-1:0] exp_last_dest;
        int            exp_period;
        logic          exp_terr;
    } vec_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            n_req = 0;
    int            n_req_zero = 0;
    int            n_done = 0;
    int            done_cyc = -1;
    int            t_start = 0;
    int            ready_mode = 0;
    logic [AW-1:0] silent_addr = '0;
    beat_t         beats[$];
    vec_t          vecs[6];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Endpoint model: answers two cycles after the request handshake.
    initial begin : responder
        logic          p1_v, p2_v;
        logic [DW-1:0] p1_d, p2_d;
        p1_v = 1'b0; p2_v = 1'b0; p1_d = '0; p2_d = '0;
        forever begin
            @(negedge clock);
            if (req_valid && req_ready) begin
                n_req++;
                if (req_data == '0) n_req_zero++;
                if (req_data[AW-1:0] != silent_addr) begin
                    p1_v = 1'b1;
                    p1_d = 32'h100 + req_data;
                end
            end
            @(posedge clock);
            #1;
            resp_valid = p2_v;
            resp_data  = p2_d;
            p2_v = p1_v; p2_d = p1_d;
            p1_v = 1'b0; p1_d = '0;
        end
    end

    // Output beats, stall stability and done pulses.
    initial begin : out_monitor
        logic          prev_stall;
        logic [DW-1:0] pd;
        logic [AW-1:0] pdest;
        logic          pl;
        beat_t         b;
        prev_stall = 1'b0; pd = '0; pdest = '0; pl = 1'b0;
        forever begin
            @(negedge clock);
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", out_data, pd);
                chk("stall_dest", {24'd0, out_dest}, {24'd0, pdest});
                chk("stall_tlast", {31'd0, out_tlast}, {31'd0, pl});
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data; pdest = out_dest; pl = out_tlast;
            if (out_valid && out_ready) begin
                b.data = out_data; b.dest = out_dest; b.last = out_tlast; b.c = cyc;
                beats.push_back(b);
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    // data_out ready: 0 = always high, 1 = low 5 cycles per beat, 2 = manual.
    initial begin : ready_driver
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clock);
            #1;
            if (ready_mode == 0) begin
                out_ready = 1'b1;
            end else if (ready_mode == 1) begin
                if (out_valid && cnt < 5) begin
                    out_ready = 1'b0;
                    cnt++;
                end else if (out_valid) begin
                    out_ready = 1'b1;
                    cnt = 0;
                end else begin
                    out_ready = 1'b0;
                    cnt = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        beats.delete();
        n_req = 0;
        n_req_zero = 0;
        n_done = 0;
        done_cyc = -1;
    endtask

    // One-cycle start; inputs are scrambled afterwards to prove they were latched.
    task automatic kick(input logic [AW-1:0] b, input logic [CW-1:0] n);
        @(posedge clock);
        #1;
        base_address = b;
        n_channels   = n;
        start        = 1'b1;
        t_start      = cyc;
        @(posedge clock);
        #1;
        start        = 1'b0;
        base_address = 8'hA5;
        n_channels   = 5'd7;
    endtask

    task automatic wait_and_check(input string tag, input vec_t v);
        int            nb;
        logic [AW-1:0] ed;
        logic [DW-1:0] edata;
        for (int i = 0; i < 800 && n_done == 0; i++) begin
            @(negedge clock);
            #1;
        end
        chk({tag, "_done_seen"}, {31'd0, (n_done > 0)}, 32'd1);
        repeat (3) @(negedge clock);
        #1;
        chk({tag, "_done_once"}, n_done, 32'd1);
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({tag, "_terr"}, {31'd0, timeout_error}, {31'd0, v.exp_terr});
        chk({tag, "_beats"}, beats.size(), v.exp_beats);
        chk({tag, "_reqs"}, n_req, v.exp_reqs);
        chk({tag, "_req_addr0"}, n_req_zero, 32'd0);
        nb = (beats.size() < v.exp_beats) ? beats.size() : v.exp_beats;
        if (beats.size() > 0) begin
            chk({tag, "_last_dest"}, {24'd0, beats[beats.size()-1].dest}, {24'd0, v.exp_last_dest});
            chk({tag, "_done_lat"}, done_cyc, beats[beats.size()-1].c + 1);
        end else begin
            chk({tag, "_done_lat"}, done_cyc, t_start + 1);
        end
        for (int i = 0; i < nb; i++) begin
            ed    = v.base + AW'(i);
            edata = (ed == '0 || ed == silent_addr) ? 32'd0 : (32'h100 + {24'd0, ed});
            chk({tag, "_dest"}, {24'd0, beats[i].dest}, {24'd0, ed});
            chk({tag, "_data"}, beats[i].data, edata);
            chk({tag, "_tlast"}, {31'd0, beats[i].last}, {31'd0, (i == v.exp_beats - 1)});
            if (v.exp_period != 0 && i > 0)
                chk({tag, "_period"}, beats[i].c - beats[i-1].c, v.exp_period);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        clear_obs();
        ready_mode = v.ready_mode;
        kick(v.base, v.n);
        // Cycle after start: request valid (unless address 0), busy, or done for n=0.
        chk({tag, "_t1_busy"}, {31'd0, busy}, {31'd0, (v.n != 0)});
        chk({tag, "_t1_req_valid"}, {31'd0, req_valid}, {31'd0, (v.n != 0 && v.base != 0)});
        chk({tag, "_t1_done"}, {31'd0, done}, {31'd0, (v.n == 0)});
        wait_and_check(tag, v);
        ready_mode = 0;
    endtask

    initial begin : main
        vec_t vi;
        //          base    n      rdy beats reqs last   period terr
        vecs[0] = '{8'h05, 5'd3,  0,  3,    3,   8'h07, 4,     1'b0};
        vecs[1] = '{8'hFE, 5'd3,  1,  3,    2,   8'h00, 0,     1'b0};
        vecs[2] = '{8'h30, 5'd0,  0,  0,    0,   8'h00, 0,     1'b0};
        vecs[3] = '{8'h10, 5'd20, 0,  16,   16,  8'h1F, 4,     1'b0};
        vecs[4] = '{8'hF8, 5'd16, 0,  16,   15,  8'h07, 0,     1'b0};
        vecs[5] = '{8'h00, 5'd1,  0,  1,    0,   8'h00, 0,     1'b0};

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        chk("rst_resp_ready", {31'd0, resp_ready}, 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_req_data", req_data, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_dest", {24'd0, out_dest}, 32'd0);
        chk("rst_out_tlast", {31'd0, out_tlast}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_terr", {31'd0, timeout_error}, 32'd0);

        for (int k = 0; k < 6; k++) begin
            run_vec($sformatf("vec%0d", k), vecs[k]);
        end

        // Reset while waiting for a response: outputs clear, late response dropped.
        clear_obs();
        kick(8'h05, 5'd3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (req_valid && req_ready) break;
        end
        @(posedge clock);
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("mid_resp_ready", {31'd0, resp_ready}, 32'd1);
        chk("mid_req_valid", {31'd0, req_valid}, 32'd0);
        chk("mid_req_data", req_data, 32'd0);
        chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_out_data", out_data, 32'd0);
        chk("mid_out_dest", {24'd0, out_dest}, 32'd0);
        chk("mid_busy_clr", {31'd0, busy}, 32'd0);
        chk("mid_done", {31'd0, done}, 32'd0);
        beats.delete();
        n_done = 0;
        repeat (12) @(negedge clock);
        #1;
        chk("mid_no_done", n_done, 32'd0);
        chk("mid_no_beats", beats.size(), 32'd0);
        chk("mid_idle", {31'd0, busy}, 32'd0);
        run_vec("post_rst", vecs[0]);

        // Start pulsed while stalled in OUTPUT is ignored.
        clear_obs();
        ready_mode = 2;
        out_ready  = 1'b0;
        kick(8'h05, 5'd3);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (out_valid) break;
        end
        @(posedge clock);
        #1;
        base_address = 8'h40;
        n_channels   = 5'd1;
        start        = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("ign_busy", {31'd0, busy}, 32'd1);
        chk("ign_dest_held", {24'd0, out_dest}, 32'h05);
        out_ready  = 1'b1;
        ready_mode = 0;
        vi = '{8'h05, 5'd3, 0, 3, 3, 8'h07, 0, 1'b0};
        wait_and_check("ign", vi);

`ifdef FCORE_DMA_READ_TIMEOUT_EN
        // Endpoint silent on address 9: zero beat, sticky error, sweep completes.
        silent_addr = 8'h09;
        vi = '{8'h08, 5'd3, 0, 3, 3, 8'h0A, 0, 1'b1};
        run_vec("tmo", vi);
        silent_addr = 8'h00;
        // Next accepted start clears the flag.
        run_vec("tmo_clr", vecs[0]);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fcore_dma_read_initiator
`default_nettype wire
